seq_detect_moore_p: RTL and testbench
=====================================

Name: seq_detect_moore_p

Overview:
- Parametrised Moore serial-pattern detector. Successor to the fixed single-pattern Moore FSM.
- Adds a runtime-loadable pattern and length, selectable overlap or non-overlap mode, a bit-enable qualifier, and a saturating match counter.
- Sits on a serial bit stream in the control path. Its registered output z drives downstream handshake and flag logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2)
- LEN_W, 4, width of length fields; must hold the value PAT_W
- CNT_W, 8, match counter width
- DEF_PATTERN, 8'b0000_1101, pattern loaded at reset (LSB-aligned)
- DEF_LEN, 4, pattern length loaded at reset (1..PAT_W)
- DEF_OVERLAP, 1, overlap mode loaded at reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- en  in  1  bit-valid; a is consumed only on edges where en=1
- a  in  1  serial data bit
- cfg_load  in  1  load strobe for cfg_pattern, cfg_len and cfg_overlap
- cfg_pattern  in  PAT_W  new pattern, LSB-aligned
- cfg_len  in  LEN_W  new pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed
- clr_cnt  in  1  synchronous clear of match_cnt
- z  out  1  Moore match output
- match_cnt  out  CNT_W  saturating count of matches
- fill  out  LEN_W  number of valid history bits, range 0..len

Behaviour:
Reset (rst=0, asynchronous, takes effect immediately):
- hist=0, fill=0, z=0, match_cnt=0
- pat=DEF_PATTERN, len=DEF_LEN, ovl=DEF_OVERLAP

Bit order:
- The oldest bit of a candidate is compared with pat[len-1]; the newest bit with pat[0].
- Only pat[len-1:0] is significant. Higher pattern bits and higher history bits are ignored.

Config load (cfg_load=1 at an edge):
- If 1<=cfg_len<=PAT_W: pat, len and ovl take the new values; hist, fill and z clear to 0.
- Otherwise the load is rejected. Config registers and detector state are unchanged.
- In either case en is ignored on that edge. cfg_load has priority over en.

Accepted bit (en=1, cfg_load=0):
- nh = {hist[PAT_W-2:0], a}
- nf = min(fill+1, len)
- m = (nf==len) && (nh[len-1:0]==pat[len-1:0])
- Updates: hist<=nh; z<=m.
- fill<=nf, except when m=1 and ovl=0, where fill<=0. This clears history validity, so the next match needs len fresh bits.

Idle edge (en=0, cfg_load=0):
- hist, fill and z hold. z stays asserted until the next accepted bit, a successful cfg_load, or reset.

Output timing:
- z is purely registered state, with no combinational path from a or en. It is high exactly on the edge that accepts the final pattern bit.
- Latency from the last pattern bit to z=1 is one edge.

Match counter:
- On m=1, match_cnt increments and saturates at 2^CNT_W-1.
- clr_cnt=1 clears it to 0. clr_cnt has priority: a coincident match is not counted.
- clr_cnt does not affect z, hist or fill.

Length-1 patterns:
- m is evaluated on every accepted bit.
- With ovl=0, fill returns to 0 after a match and re-fills to 1 on the next accepted bit, so consecutive matches are still possible.

Structure:
- States are encoded by (fill, hist, z); no separate next-state table.
- Implement as one sequential always block plus combinational m/nh/nf logic.

Test Plan:
1. Reset defaults (pattern 1101, len 4, overlap on). Stream 1,1,0,1,1,0,1 with en=1 every edge -> z=1 after bit 4 and after bit 7 only; match_cnt=2; fill=4 after bit 4.
2. cfg_load: pattern 1101, len 4, overlap 0. Same stream -> z=1 after bit 4 only; fill sequence 1,2,3,0,1,2,3; match_cnt=1.
3. Gaps in en. Default config; 1,1,0,1 delivered with en low for 3 edges between each bit -> z stays 0 through the gaps, rises on the edge accepting the final 1, and holds 1 while en=0 afterwards; match_cnt=1.
4. Config errors and priority:
   - cfg_len=0 -> rejected; len stays 4; behaviour is unchanged on the replay of scenario 1.
   - Valid load of pattern 8'b1010_0110, len 8, issued while z=1 -> z=0, fill=0 next edge.
   - Stream 1,0,1,0,0,1,1,0 -> z=1 on the 8th bit.
5. Counter behaviour, CNT_W=2, len-1 pattern 1:
   - Six consecutive 1s -> match_cnt sequence 1,2,3,3,3,3 (saturates).
   - clr_cnt asserted on a matching edge -> match_cnt=0; z=1 still.
6. Mid-stream reset:
   - Assert rst low asynchronously between edges after 3 bits of 1101 -> z, fill, match_cnt and hist are 0 immediately.
   - Config returns to defaults.
   - After release, a single 1 gives no match; a full 1,1,0,1 is required.

Source files
------------

// File: rtl/seq_detect_moore_p.sv
// Parametrised Moore serial-pattern detector.
// The detector watches a serial bit stream and raises a registered flag z on
// the edge that accepts the final bit of a runtime-loadable pattern. Pattern,
// length and overlap mode can be reloaded while running. A saturating counter
// tallies matches.
//
// The detector "state" is the tuple (fill, hist, z) rather than an enumerated
// FSM. A pattern of up to PAT_W bits would otherwise need a state table that
// changes whenever the pattern is reloaded, so the history shift register
// replaces that table.
module seq_detect_moore_p #(
  parameter int                PAT_W       = 8,
  parameter int                LEN_W       = 4,
  parameter int                CNT_W       = 8,
  parameter logic [PAT_W-1:0]  DEF_PATTERN = PAT_W'(8'b0000_1101),
  parameter logic [LEN_W-1:0]  DEF_LEN     = LEN_W'(4),
  parameter logic              DEF_OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active low
  input  logic             en,
  input  logic             a,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] fill
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Configuration registers.
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;

  // Detector state. The history keeps only PAT_W-1 past bits. The candidate
  // window is those bits plus the bit arriving now, so the oldest bit of a
  // full-width window is never needed after the edge that uses it.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             z_q,    z_d;

  // Match counter.
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [PAT_W-1:0] len_mask;   // ones in bit positions [len-1:0]
  logic [PAT_W-1:0] nh;         // candidate window including the incoming bit
  logic [LEN_W-1:0] nf;         // fill count if this bit is accepted
  logic             m;          // window matches the pattern
  logic             cfg_ok;     // requested length lies in 1..PAT_W
  logic             take_bit;   // this edge consumes a
  logic             cnt_sat;    // counter is at its maximum value

  // Build the significance mask, the candidate window and the match decision.
  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a value on every
    // path (defaults first). Otherwise a latch is inferred.
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end

    nh = {hist_q, a};

    if (fill_q < len_q) begin
      nf = fill_q + LEN_W'(1);
    end else begin
      nf = len_q;
    end

    // Only pat[len-1:0] and nh[len-1:0] matter. The mask hides the rest.
    m = (nf == len_q) && (((nh ^ pat_q) & len_mask) == '0);

    cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    take_bit = en && !cfg_load;
    cnt_sat  = &cnt_q;
  end

  // Next-state logic. Configuration load takes priority over bit acceptance.
  // Idle edges hold everything.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = z_q;

    if (cfg_load) begin
      // A rejected load leaves configuration and detector state untouched.
      // The bit offered on this edge is dropped in either case.
      if (cfg_ok) begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        hist_d = '0;
        fill_d = '0;
        z_d    = 1'b0;
      end
    end else if (en) begin
      hist_d = nh[PAT_W-2:0];
      z_d    = m;
      // In non-overlap mode a match invalidates the history, so the next
      // match needs a complete fresh pattern.
      if (m && !ovl_q) begin
        fill_d = '0;
      end else begin
        fill_d = nf;
      end
    end
  end

  // Counter next value. A clear wins over a coincident match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (take_bit && m && !cnt_sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the pre-edge values regardless of statement order.
    if (!rst) begin
      // Reset clears all state, including the history shift register. The
      // history is a few flops, not a memory array, and it must read as zero
      // so no stale bits can form a match after reset.
      pat_q  <= DEF_PATTERN;
      len_q  <= DEF_LEN;
      ovl_q  <= DEF_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs come straight from flops, with no path from a or en.
  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_moore_p.sv
// Testbench for seq_detect_moore_p.
// Table-driven vectors feed a scoreboard queue. Each vector's expected outputs
// are queued when it is driven and compared one edge later. A second instance
// with a 2-bit counter exercises saturation.
module tb_seq_detect_moore_p;

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       en;
    logic       a;
    logic       clr;
    logic       ez;
    logic [3:0] efill;
    logic [7:0] ecnt;
    logic       c2;     // compare ecnt against the 2-bit-counter instance
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, a, cfg_load, cfg_overlap, clr_cnt;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       z, z2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic [3:0] fill, fill2;

  int n_vectors     = 0;
  int n_miscompares = 0;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  seq_detect_moore_p dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt), .z(z), .match_cnt(match_cnt), .fill(fill)
  );

  seq_detect_moore_p #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .en(en), .a(a), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt), .z(z2), .match_cnt(match_cnt2), .fill(fill2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                              input logic ovl, input logic en_i, input logic a_i,
                              input logic clr, input logic ez, input logic [3:0] ef,
                              input logic [7:0] ec, input logic c2);
    vec_t v;
    v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.en = en_i; v.a = a_i;
    v.clr = clr; v.ez = ez; v.efill = ef; v.ecnt = ec; v.c2 = c2;
    return v;
  endfunction

  // Accepted bit, checked against the 8-bit counter.
  function automatic vec_t b(input logic a_i, input logic ez, input logic [3:0] ef, input logic [7:0] ec);
    return mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, a_i, 1'b0, ez, ef, ec, 1'b0);
  endfunction

  // Accepted bit, checked against the 2-bit counter.
  function automatic vec_t b2(input logic a_i, input logic ez, input logic [3:0] ef, input logic [7:0] ec);
    return mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, a_i, 1'b0, ez, ef, ec, 1'b1);
  endfunction

  // Idle edge (en low) with a junk data bit.
  function automatic vec_t g(input logic a_i, input logic ez, input logic [3:0] ef, input logic [7:0] ec);
    return mk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, a_i, 1'b0, ez, ef, ec, 1'b0);
  endfunction

  task automatic idle_inputs();
    en = 1'b0; a = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    en = v.en; a = v.a; cfg_load = v.ld; cfg_pattern = v.pat;
    cfg_len = v.len; cfg_overlap = v.ovl; clr_cnt = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("v%0d z", idx), 32'(z), 32'(e.ez));
    check($sformatf("v%0d z(c2)", idx), 32'(z2), 32'(e.ez));
    check($sformatf("v%0d fill", idx), 32'(fill), 32'(e.efill));
    check($sformatf("v%0d fill(c2)", idx), 32'(fill2), 32'(e.efill));
    if (e.c2) check($sformatf("v%0d cnt(c2)", idx), 32'(match_cnt2), 32'(e.ecnt));
    else      check($sformatf("v%0d cnt", idx), 32'(match_cnt), 32'(e.ecnt));
  endtask

  initial begin
    // Defaults: 1101, len 4, overlap on. Stream 1,1,0,1,1,0,1.
    tbl_a.push_back(b(1,0,1,0)); tbl_a.push_back(b(1,0,2,0)); tbl_a.push_back(b(0,0,3,0));
    tbl_a.push_back(b(1,1,4,1)); tbl_a.push_back(b(1,0,4,1)); tbl_a.push_back(b(0,0,4,1));
    tbl_a.push_back(b(1,1,4,2));
    // Non-overlap load of 1101. The upper pattern bits are set but ignored.
    // The counter is cleared in the same cycle. z clears.
    tbl_a.push_back(mk(1, 8'hFD, 4'd4, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl_a.push_back(b(1,0,1,0)); tbl_a.push_back(b(1,0,2,0)); tbl_a.push_back(b(0,0,3,0));
    tbl_a.push_back(b(1,1,0,1)); tbl_a.push_back(b(1,0,1,1)); tbl_a.push_back(b(0,0,2,1));
    tbl_a.push_back(b(1,0,3,1));
    // Back to default config, then bits separated by en gaps.
    tbl_a.push_back(mk(1, 8'h0D, 4'd4, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl_a.push_back(b(1,0,1,0));
    tbl_a.push_back(g(0,0,1,0)); tbl_a.push_back(g(1,0,1,0)); tbl_a.push_back(g(1,0,1,0));
    tbl_a.push_back(b(1,0,2,0));
    tbl_a.push_back(g(0,0,2,0)); tbl_a.push_back(g(0,0,2,0)); tbl_a.push_back(g(1,0,2,0));
    tbl_a.push_back(b(0,0,3,0));
    tbl_a.push_back(g(1,0,3,0)); tbl_a.push_back(g(1,0,3,0)); tbl_a.push_back(g(1,0,3,0));
    tbl_a.push_back(b(1,1,4,1));
    tbl_a.push_back(g(1,1,4,1)); tbl_a.push_back(g(0,1,4,1)); tbl_a.push_back(g(1,1,4,1));
    // Rejected loads (len 0, len 9) while en=1. Nothing changes.
    tbl_a.push_back(mk(1, 8'hFF, 4'd0, 0, 1, 1, 0, 1, 4, 1, 0));
    tbl_a.push_back(mk(1, 8'h00, 4'd9, 0, 1, 0, 0, 1, 4, 1, 0));
    // Replay the first stream. History 1101 is still valid, overlap is still on.
    tbl_a.push_back(b(1,0,4,1)); tbl_a.push_back(b(1,0,4,1)); tbl_a.push_back(b(0,0,4,1));
    tbl_a.push_back(b(1,1,4,2)); tbl_a.push_back(b(1,0,4,2)); tbl_a.push_back(b(0,0,4,2));
    tbl_a.push_back(b(1,1,4,3));
    // Full-width pattern loaded while z=1.
    tbl_a.push_back(mk(1, 8'hA6, 4'd8, 1, 0, 0, 0, 0, 0, 3, 0));
    tbl_a.push_back(b(1,0,1,3)); tbl_a.push_back(b(0,0,2,3)); tbl_a.push_back(b(1,0,3,3));
    tbl_a.push_back(b(0,0,4,3)); tbl_a.push_back(b(0,0,5,3)); tbl_a.push_back(b(1,0,6,3));
    tbl_a.push_back(b(1,0,7,3)); tbl_a.push_back(b(0,1,8,4));
    // Length-1 pattern '1', non-overlap. The 2-bit counter saturates.
    tbl_a.push_back(mk(1, 8'h01, 4'd1, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl_a.push_back(b2(1,1,0,1)); tbl_a.push_back(b2(1,1,0,2)); tbl_a.push_back(b2(1,1,0,3));
    tbl_a.push_back(b2(1,1,0,3)); tbl_a.push_back(b2(1,1,0,3)); tbl_a.push_back(b2(1,1,0,3));
    // Clear coincident with a match. The match is not counted and z still rises.
    tbl_a.push_back(mk(0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 0, 0, 1));
    tbl_a.push_back(b2(0,0,1,0)); tbl_a.push_back(b2(1,1,0,1));
    // Three bits before the mid-stream reset.
    tbl_a.push_back(b2(1,1,0,2)); tbl_a.push_back(b2(1,1,0,3)); tbl_a.push_back(b2(0,0,1,3));

    // After reset: the default config is back, so one 1 is not enough, and the
    // overlapping second match needs len 4.
    tbl_b.push_back(b(1,0,1,0)); tbl_b.push_back(b(1,0,2,0)); tbl_b.push_back(b(0,0,3,0));
    tbl_b.push_back(b(1,1,4,1)); tbl_b.push_back(b(1,0,4,1)); tbl_b.push_back(b(0,0,4,1));
    tbl_b.push_back(b(1,1,4,2));

    idle_inputs();
    rst = 1'b0;
    #3;
    check("reset z", 32'(z), 32'd0);
    check("reset fill", 32'(fill), 32'd0);
    check("reset cnt", 32'(match_cnt), 32'd0);
    #5 rst = 1'b1;

    for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i], i);

    // Asynchronous reset between edges.
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    check("midrst z", 32'(z), 32'd0);
    check("midrst fill", 32'(fill), 32'd0);
    check("midrst cnt", 32'(match_cnt), 32'd0);
    check("midrst cnt(c2)", 32'(match_cnt2), 32'd0);
    check("midrst hist", 32'(dut.hist_q), 32'd0);
    #1 rst = 1'b1;

    for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], 1000 + i);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
